serial_fa_adder: RTL

Bit-serial ripple adder built around the team's 1-bit full-adder cell (sum = a^b^cin, cout = majority(a,b,cin)) with a registered carry.
- Accepts two WIDTH-bit operands plus carry-in on a start handshake.
- Feeds one operand bit pair per clock, LSB first, through the full-adder stage.
- Presents the WIDTH-bit sum and carry-out with a one-cycle done pulse.
- Sits directly downstream of operand sources and wraps the full-adder cell as its per-bit datapath.

---
 rtl/serial_fa_adder.sv | 113 +++++++++++
 1 files changed

// File: rtl/serial_fa_adder.sv
// Bit-serial ripple adder: one full-adder step per clock, LSB first,
// with a registered carry. {cout,sum} = a + b + cin after WIDTH shift cycles.
module serial_fa_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] res_nxt;
  logic             carry;
  logic             carry_nxt;
  logic             s;
  logic [CW-1:0]    cnt;
  logic             last;

  // Full-adder cell on the current LSB pair plus the result shifted with the new bit
  always_comb begin
    s         = a_sr[0] ^ b_sr[0] ^ carry;
    carry_nxt = (a_sr[0] & b_sr[0]) | (b_sr[0] & carry) | (a_sr[0] & carry);
    res_nxt   = (res_sr >> 1) | ({{(WIDTH-1){1'b0}}, s} << (WIDTH - 1));
    last      = (cnt == LAST);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic and status outputs decoded from state
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, bit-serial datapath and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= cin;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          carry  <= carry_nxt;
          res_sr <= res_nxt;
          if (last) begin
            // sum/cout are only published here, so they never expose partial bits
            sum  <= res_nxt;
            cout <= carry_nxt;
            cnt  <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
